// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-word SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// A transfer runs IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE. Each phase is
// CLK_DIV clk cycles long. All outputs come straight from flops.
module spi_master_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  // Half-period counter width: holds 0..CLK_DIV-1 without wrapping inside a phase.
  localparam int CW = $clog2(CLK_DIV + 1);
  // Bit index width: counts completed sclk falling edges 0..DATA_WIDTH-1.
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0]         CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]         CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0]         BIT_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0]         BIT_ONE   = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]         BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SETUP    = 2'b01,
    TRANSFER = 2'b10,
    HOLD     = 2'b11
  } state_t;

  state_t                state_r, state_s;
  logic [CW-1:0]         cnt_r, cnt_s;
  logic [BW-1:0]         bit_r, bit_s;
  logic [DATA_WIDTH-1:0] tx_sh_r, tx_sh_s;
  logic [DATA_WIDTH-1:0] rx_sh_r, rx_sh_s;
  logic [DATA_WIDTH-1:0] rx_data_r, rx_data_s;
  logic                  sclk_r, sclk_s;
  logic                  mosi_r, mosi_s;
  logic                  cs_n_r, cs_n_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic [DATA_WIDTH-1:0] tx_shl_s;
  logic [DATA_WIDTH-1:0] rx_shl_s;
  logic                  phase_end_s;

  // Next-state and next-output logic; every register holds unless a phase ends.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_s       = bit_r;
    tx_sh_s     = tx_sh_r;
    rx_sh_s     = rx_sh_r;
    rx_data_s   = rx_data_r;
    sclk_s      = sclk_r;
    mosi_s      = mosi_r;
    cs_n_s      = cs_n_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    tx_shl_s    = tx_sh_r << 1;
    rx_shl_s    = {rx_sh_r[DATA_WIDTH-2:0], miso};
    phase_end_s = (cnt_r == CNT_LAST);

    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SETUP;
          cnt_s   = CNT_ZERO;
          bit_s   = BIT_ZERO;
          tx_sh_s = tx_data;
          rx_sh_s = WORD_ZERO;
          mosi_s  = tx_data[DATA_WIDTH-1];
          sclk_s  = 1'b0;
          cs_n_s  = 1'b0;
          busy_s  = 1'b1;
        end else begin
          mosi_s  = 1'b0;
          sclk_s  = 1'b0;
          cs_n_s  = 1'b1;
          busy_s  = 1'b0;
        end
      end

      SETUP: begin
        // First rising sclk edge ends the setup phase and samples miso.
        if (phase_end_s) begin
          state_s = TRANSFER;
          cnt_s   = CNT_ZERO;
          sclk_s  = 1'b1;
          rx_sh_s = rx_shl_s;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end

      TRANSFER: begin
        if (phase_end_s) begin
          cnt_s = CNT_ZERO;
          if (sclk_r) begin
            // Falling edge: present the next bit, or finish after the last one.
            sclk_s = 1'b0;
            if (bit_r == BIT_LAST) begin
              state_s = HOLD;
            end else begin
              bit_s   = bit_r + BIT_ONE;
              tx_sh_s = tx_shl_s;
              mosi_s  = tx_shl_s[DATA_WIDTH-1];
            end
          end else begin
            // Rising edge: sample miso into the receive register LSB.
            sclk_s  = 1'b1;
            rx_sh_s = rx_shl_s;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      HOLD: begin
        if (phase_end_s) begin
          state_s   = IDLE;
          cnt_s     = CNT_ZERO;
          cs_n_s    = 1'b1;
          busy_s    = 1'b0;
          done_s    = 1'b1;
          mosi_s    = 1'b0;
          rx_data_s = rx_sh_r;
        end else begin
          cnt_s     = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        sclk_s  = 1'b0;
        mosi_s  = 1'b0;
        cs_n_s  = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters, shift registers and output flops; reset wins over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_r     <= BIT_ZERO;
      tx_sh_r   <= WORD_ZERO;
      rx_sh_r   <= WORD_ZERO;
      rx_data_r <= WORD_ZERO;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_r     <= bit_s;
      tx_sh_r   <= tx_sh_s;
      rx_sh_r   <= rx_sh_s;
      rx_data_r <= rx_data_s;
      sclk_r    <= sclk_s;
      mosi_r    <= mosi_s;
      cs_n_r    <= cs_n_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign rx_data = rx_data_r;
  assign sclk    = sclk_r;
  assign mosi    = mosi_r;
  assign cs_n    = cs_n_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: stimulus pushes expected transfers,
// a negedge monitor (with a simple SPI slave) pops and compares on done.
module tb_spi_master_ctrl;

  localparam int LAT  = 68;  // (2*8+1)*4
  localparam int LAT2 = 34;  // (2*8+1)*2

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_rx;
    int         e0;
    logic       b2b;
  } item_t;

  typedef struct {
    logic [7:0] exp_rx;
    int         e0;
  } item2_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy, done, sclk, mosi, cs_n, miso_w;
  logic [7:0] rx_data;

  logic       start2 = 1'b0;
  logic [7:0] tx2 = 8'h00;
  logic       busy2, done2, sclk2, mosi2, cs_n2;
  logic [7:0] rx_data2;

  logic       loop = 1'b0;
  logic [7:0] slv_word = 8'h00;
  logic       miso_s = 1'b0;

  int         edge_n = 0;
  logic       rst_seen = 1'b1;
  int         total = 0;
  int         bad = 0;

  item_t      sb_q[$];
  item2_t     q2[$];

  // monitor state
  logic       prev_sclk = 1'b0, prev_cs = 1'b1, prev_sclk2 = 1'b0;
  int         rises = 0, cs_low = 0, busy_cnt = 0, cs_high = 0, gap_before = 0, rises2 = 0;
  logic [7:0] got = 8'h00, slv_sh = 8'h00, model_rx = 8'h00, model_rx2 = 8'h00;
  item_t      mit;
  item2_t     mit2;

  always #5 clk = ~clk;

  assign miso_w = loop ? mosi : miso_s;

  spi_master_ctrl #(.CLK_DIV(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .mosi(mosi), .miso(miso_w), .cs_n(cs_n)
  );

  spi_master_ctrl #(.CLK_DIV(2), .DATA_WIDTH(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .tx_data(tx2),
    .busy(busy2), .done(done2), .rx_data(rx_data2),
    .sclk(sclk2), .mosi(mosi2), .miso(mosi2), .cs_n(cs_n2)
  );

  // edge counter and reset-seen flag
  always @(posedge clk) begin
    edge_n   <= edge_n + 1;
    rst_seen <= reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // monitor, slave and scoreboard checker
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst2_cs_n", cs_n2, 1);
        check("rst2_rx_data", rx_data2, 0);
        model_rx = 8'h00; model_rx2 = 8'h00;
        rises = 0; got = 8'h00; cs_low = 0; busy_cnt = 0; rises2 = 0;
        cs_high = cs_high + 1;
      end else begin
        if (cs_n) begin
          check("idle_sclk", sclk, 0);
          check("idle_mosi", mosi, 0);
        end
        if (sclk && !prev_sclk) begin
          rises++;
          got = {got[6:0], mosi};
        end
        if (!cs_n) cs_low++;
        if (busy) busy_cnt++;
        if (!cs_n && prev_cs) begin
          gap_before = cs_high;
          slv_sh = slv_word;
        end else if (!cs_n && prev_sclk && !sclk) begin
          slv_sh = {slv_sh[6:0], 1'b0};
        end
        cs_high = cs_n ? cs_high + 1 : 0;

        if (done) begin
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_done: got a done pulse, want none (edge %0d)", edge_n);
          end else begin
            mit = sb_q.pop_front();
            check("latency", edge_n - mit.e0, LAT);
            check("rx_data_done", rx_data, mit.exp_rx);
            check("sclk_rises", rises, 8);
            check("mosi_bits", got, mit.tx);
            check("cs_low_cycles", cs_low, LAT);
            check("busy_cycles", busy_cnt, LAT);
            if (mit.b2b) check("cs_gap", gap_before, 1);
            model_rx = mit.exp_rx;
          end
          rises = 0; got = 8'h00; cs_low = 0; busy_cnt = 0;
        end else if (sb_q.size() != 0 && edge_n > sb_q[0].e0 + LAT + 8) begin
          total++; bad++;
          $display("FAIL done_timeout: got no done by edge %0d, want one at edge %0d", edge_n, sb_q[0].e0 + LAT);
          void'(sb_q.pop_front());
        end
        check("rx_data_hold", rx_data, model_rx);

        if (sclk2 && !prev_sclk2) rises2++;
        if (cs_n2) check("idle2_sclk", sclk2, 0);
        if (done2) begin
          if (q2.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_done2: got a done pulse, want none (edge %0d)", edge_n);
          end else begin
            mit2 = q2.pop_front();
            check("latency2", edge_n - mit2.e0, LAT2);
            check("rx_data2_done", rx_data2, mit2.exp_rx);
            check("sclk_rises2", rises2, 8);
            model_rx2 = mit2.exp_rx;
          end
          rises2 = 0;
        end else if (q2.size() != 0 && edge_n > q2[0].e0 + LAT2 + 8) begin
          total++; bad++;
          $display("FAIL done2_timeout: got no done by edge %0d, want one at edge %0d", edge_n, q2[0].e0 + LAT2);
          void'(q2.pop_front());
        end
        check("rx_data2_hold", rx_data2, model_rx2);
      end
      miso_s     = slv_sh[7];
      prev_sclk  = sclk;
      prev_cs    = cs_n;
      prev_sclk2 = sclk2;
    end
  end

  task automatic xfer(input logic [7:0] tx, input logic lp, input logic [7:0] sw,
                      input int gap, input bit mid_start);
    item_t it;
    int t;
    int e0;
    repeat (gap) @(negedge clk);
    t = 0;
    while (busy === 1'b1 && t < 200) begin @(negedge clk); t++; end
    tx_data = tx; loop = lp; slv_word = sw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = edge_n;
    it.tx = tx; it.exp_rx = lp ? tx : sw; it.e0 = e0; it.b2b = 1'b0;
    sb_q.push_back(it);
    if (mid_start) begin
      while (edge_n < e0 + 19) @(negedge clk);
      start = 1'b1; tx_data = ~tx;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (sb_q.size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (mid_start) repeat (LAT + 10) @(negedge clk);
  endtask

  task automatic xfer2(input logic [7:0] tx);
    item2_t it;
    int t;
    t = 0;
    while (busy2 === 1'b1 && t < 200) begin @(negedge clk); t++; end
    tx2 = tx; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    it.exp_rx = tx; it.e0 = edge_n;
    q2.push_back(it);
    t = 0;
    while (q2.size() != 0 && t < 200) begin @(negedge clk); t++; end
  endtask

  // stimulus sequence
  initial begin : stim
    item_t it;
    int e0;
    int t;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    xfer(8'hA5, 1'b1, 8'h00, 0, 1'b0);
    xfer(8'h00, 1'b0, 8'hFF, 1, 1'b0);
    for (int i = 0; i < 12; i++)
      xfer(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), $urandom_range(0, 3), 1'b0);

    // second start pulse in the middle of a transfer is ignored
    xfer(8'($urandom_range(0, 255)), 1'b0, 8'($urandom_range(0, 255)), 0, 1'b1);

    // reset one cycle at cycle 30 of a transfer aborts it
    xfer(8'h96, 1'b1, 8'h00, 0, 1'b0);
    tx_data = 8'h5A; loop = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = edge_n;
    while (edge_n < e0 + 29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 10) @(negedge clk);

    // start held high: two back-to-back transfers
    loop = 1'b1; tx_data = 8'h3C; start = 1'b1;
    @(negedge clk);
    e0 = edge_n;
    it.tx = 8'h3C; it.exp_rx = 8'h3C; it.e0 = e0; it.b2b = 1'b0;
    sb_q.push_back(it);
    tx_data = 8'hC3;
    while (edge_n < e0 + LAT + 1) @(negedge clk);
    it.tx = 8'hC3; it.exp_rx = 8'hC3; it.e0 = e0 + LAT + 1; it.b2b = 1'b1;
    sb_q.push_back(it);
    start = 1'b0;
    t = 0;
    while (sb_q.size() != 0 && t < 300) begin @(negedge clk); t++; end

    // CLK_DIV=2 instance, loopback
    xfer2(8'h81);
    for (int i = 0; i < 3; i++) xfer2(8'($urandom_range(0, 255)));

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // run-away guard
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
